ysyx_25030081_ifu: RTL and testbench

- Instruction fetch unit directly upstream of the single-cycle core.
- Issues one read per instruction over a valid/ready memory read interface (address channel plus data channel).
- Captures the instruction word and presents it to the core with inst/pc plus a valid/ready handshake.
- Takes the core's next_pc on acceptance to start the next fetch; one outstanding request, no prefetch.

---
 rtl/ysyx_25030081_ifu_pkg.sv | 21 ++
 rtl/ysyx_25030081_ifu.sv | 114 +++++++++++
 tb/tb_ysyx_25030081_ifu.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25030081_ifu_pkg.sv
// rtl/ysyx_25030081_ifu_pkg.sv - shared IFU constants and state encoding
// Contents:
//   ifu_state_t       3-bit fetch FSM state encoding
//   RESP_OKAY         read response code for a successful fetch
//   DEFAULT_RESET_PC  first fetch address after reset
//   EBREAK_INST       ebreak encoding, also used by the core for halt detection
package ysyx_25030081_ifu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_HOLD = 3'd3,
    ST_ERR  = 3'd4
  } ifu_state_t;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;

endpackage

// File: rtl/ysyx_25030081_ifu.sv
// rtl/ysyx_25030081_ifu.sv - instruction fetch unit, one outstanding read, no prefetch
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   inst, pc, inst_valid          fetched word and its address towards the core
//   inst_ready, next_pc           core acceptance and next fetch address
//   mem_arvalid/araddr/arready    read address channel
//   mem_rvalid/rdata/rresp/rready read data channel
//   fetch_err                     sticky error (bad response or misaligned next_pc)
//   fetch_cnt                     number of instructions accepted by the core
module ysyx_25030081_ifu
  import ysyx_25030081_ifu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  mem_arvalid,
  output logic [ADDR_WIDTH-1:0] mem_araddr,
  input  logic                  mem_arready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            mem_rresp,
  output logic                  mem_rready,
  output logic                  fetch_err,
  output logic [31:0]           fetch_cnt
);

  ifu_state_t            state;
  logic [ADDR_WIDTH-1:0] fetch_addr;

  // The address register only changes on accept, so it is stable for the
  // whole AR phase without a separate output register.
  assign mem_araddr = fetch_addr;

  // All handshake outputs are registered and set on the transition into the
  // state that owns them, so they are never asserted outside that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      fetch_addr  <= RESET_PC;
      pc          <= RESET_PC;
      inst        <= '0;
      inst_valid  <= 1'b0;
      mem_arvalid <= 1'b0;
      mem_rready  <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_cnt   <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state       <= ST_AR;
          mem_arvalid <= 1'b1;
        end
        ST_AR: begin
          if (mem_arready) begin
            state       <= ST_R;
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b1;
          end
        end
        ST_R: begin
          if (mem_rvalid) begin
            mem_rready <= 1'b0;
            if (mem_rresp == RESP_OKAY) begin
              state      <= ST_HOLD;
              inst       <= mem_rdata;
              pc         <= fetch_addr;
              inst_valid <= 1'b1;
            end else begin
              state     <= ST_ERR;
              fetch_err <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            fetch_cnt  <= fetch_cnt + 32'd1;
            if (next_pc[1:0] == 2'b00) begin
              state       <= ST_AR;
              fetch_addr  <= next_pc;
              mem_arvalid <= 1'b1;
            end else begin
              state     <= ST_ERR;
              fetch_err <= 1'b1;
            end
          end
        end
        ST_ERR: begin
          inst_valid  <= 1'b0;
          mem_arvalid <= 1'b0;
          mem_rready  <= 1'b0;
          fetch_err   <= 1'b1;
        end
        default: begin
          // Unreachable encodings park in the terminal error state.
          state       <= ST_ERR;
          inst_valid  <= 1'b0;
          mem_arvalid <= 1'b0;
          mem_rready  <= 1'b0;
          fetch_err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030081_ifu.sv
// tb/tb_ysyx_25030081_ifu.sv - self-checking bench for ysyx_25030081_ifu
module tb_ysyx_25030081_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] next_pc;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int n_chk;
  int n_fail;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  ysyx_25030081_ifu dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .pc         (pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .next_pc    (next_pc),
    .mem_arvalid(mem_arvalid),
    .mem_araddr (mem_araddr),
    .mem_arready(mem_arready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_rresp  (mem_rresp),
    .mem_rready (mem_rready),
    .fetch_err  (fetch_err),
    .fetch_cnt  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_ready  = 1'b0;
    next_pc     = 32'd0;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'd0;
    mem_rresp   = 2'b00;
  endtask

  // Holds reset for two cycles, checks the reset values, releases at a negedge.
  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_arvalid", mem_arvalid, 0);
    chk("rst_rready", mem_rready, 0);
    chk("rst_fetch_err", fetch_err, 0);
    chk("rst_fetch_cnt", fetch_cnt, 0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 0);
    rst = 1'b1;
  endtask

  // Transaction-level reference state for the random phase.
  logic [31:0] m_addr;
  logic        m_pend;
  logic        m_have;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_ar_wait;
  logic [31:0] r;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle_inputs();
    #1 rst = 1'b0;

    // Reset release with a fully ready memory.
    do_reset();
    mem_arready = 1'b1;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'h0000_0413;
    step();
    chk("t1_arvalid", mem_arvalid, 1);
    chk("t1_araddr", mem_araddr, RST_PC);
    chk("t1_inst_valid_early", inst_valid, 0);
    step();
    chk("t1_rready", mem_rready, 1);
    chk("t1_arvalid_off", mem_arvalid, 0);
    step();
    chk("t1_inst_valid", inst_valid, 1);
    chk("t1_inst", inst, 32'h0000_0413);
    chk("t1_pc", pc, RST_PC);
    chk("t1_rready_off", mem_rready, 0);

    // Core stalls for five cycles; rvalid stays high and must be ignored.
    mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", inst_valid, 1);
      chk("t2_hold_inst", inst, 32'h0000_0413);
      chk("t2_hold_pc", pc, RST_PC);
      chk("t2_hold_cnt", fetch_cnt, 0);
    end
    inst_ready  = 1'b1;
    next_pc     = 32'h8000_0004;
    mem_arready = 1'b0;
    step();
    inst_ready = 1'b0;
    next_pc    = 32'h0;
    chk("t2_cnt_after", fetch_cnt, 1);
    chk("t2_valid_drop", inst_valid, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_ar_hold", mem_arvalid, 1);
      chk("t2_ar_addr", mem_araddr, 32'h8000_0004);
      if (i == 3) mem_arready = 1'b1;
      step();
    end
    chk("t2_r_phase", mem_rready, 1);

    // Error response while in R.
    mem_rvalid = 1'b1;
    mem_rresp  = 2'b10;
    step();
    chk("t3_fetch_err", fetch_err, 1);
    for (int i = 0; i < 6; i++) begin
      mem_arready = 1'($urandom);
      mem_rvalid  = 1'($urandom);
      mem_rresp   = 2'($urandom);
      inst_ready  = 1'($urandom);
      step();
      chk("t3_err_arvalid", mem_arvalid, 0);
      chk("t3_err_rready", mem_rready, 0);
      chk("t3_err_valid", inst_valid, 0);
      chk("t3_err_sticky", fetch_err, 1);
    end

    // Misaligned next_pc.
    do_reset();
    mem_arready = 1'b1;
    mem_rvalid  = 1'b1;
    mem_rdata   = $urandom;
    step();
    step();
    step();
    chk("t4_hold", inst_valid, 1);
    inst_ready = 1'b1;
    next_pc    = 32'h8000_0006;
    step();
    inst_ready = 1'b0;
    chk("t4_fetch_err", fetch_err, 1);
    chk("t4_cnt", fetch_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t4_no_ar", mem_arvalid, 0);
      chk("t4_no_valid", inst_valid, 0);
      step();
    end

    // Reset pulse mid-R followed by a stale response.
    do_reset();
    mem_arready = 1'b1;
    step();
    step();
    chk("t5_in_r", mem_rready, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_rready", mem_rready, 0);
    chk("t5_async_arvalid", mem_arvalid, 0);
    chk("t5_async_pc", pc, RST_PC);
    @(negedge clk);
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'hDEAD_BEEF;
    rst         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_stale_valid", inst_valid, 0);
      chk("t5_stale_inst", inst == 32'hDEAD_BEEF, 0);
      chk("t5_rready_off", mem_rready, 0);
    end
    chk("t5_new_addr", mem_araddr, RST_PC);
    chk("t5_new_ar", mem_arvalid, 1);
    mem_arready = 1'b1;
    step();
    mem_arready = 1'b0;
    mem_rdata   = 32'h0010_0073;
    chk("t5_r_again", mem_rready, 1);
    step();
    chk("t5_valid", inst_valid, 1);
    chk("t5_inst", inst, 32'h0010_0073);
    chk("t5_pc", pc, RST_PC);

    // Random traffic against a transaction-level model: each fetch address
    // is RESET_PC or the previously accepted next_pc, each presented word is
    // the data returned for that fetch, fetch_cnt counts accepts.
    do_reset();
    m_addr    = RST_PC;
    m_pend    = 1'b0;
    m_have    = 1'b0;
    m_inst    = 32'd0;
    m_pc      = RST_PC;
    m_cnt     = 32'd0;
    m_ar_wait = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (m_ar_wait) chk("rnd_ar_drop", mem_arvalid, 1);
      if (mem_arvalid) begin
        chk("rnd_ar_addr", mem_araddr, m_addr);
        chk("rnd_ar_busy", m_pend | m_have, 0);
      end
      if (mem_rready) chk("rnd_rready_no_req", m_pend, 1);
      chk("rnd_inst_valid", inst_valid, m_have);
      if (inst_valid) begin
        chk("rnd_inst", inst, m_inst);
        chk("rnd_pc", pc, m_pc);
      end
      chk("rnd_cnt", fetch_cnt, m_cnt);
      chk("rnd_no_err", fetch_err, 0);

      mem_arready = ($urandom_range(0, 3) != 0);
      mem_rvalid  = ($urandom_range(0, 2) != 0);
      mem_rdata   = $urandom;
      mem_rresp   = 2'b00;
      inst_ready  = ($urandom_range(0, 2) != 0);
      r           = $urandom;
      next_pc     = ($urandom_range(0, 3) != 0) ? (m_pc + 32'd4) : {r[31:2], 2'b00};

      m_ar_wait = mem_arvalid && !mem_arready;
      if (mem_arvalid && mem_arready) m_pend = 1'b1;
      if (mem_rready && mem_rvalid) begin
        m_pend = 1'b0;
        m_have = 1'b1;
        m_inst = mem_rdata;
        m_pc   = m_addr;
      end else if (inst_valid && inst_ready) begin
        m_have = 1'b0;
        m_cnt  = m_cnt + 32'd1;
        m_addr = next_pc;
      end
    end
    chk("rnd_progress", m_cnt > 32'd100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
